// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are available,
// snoops the writeback bus for operands and issues the lowest-index ready entry each cycle.
module alu_reservation_station #(
  parameter int unsigned ENTRY_NUM    = 8,
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned RRF_TAG_LEN  = 6,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    kill_i,
  input  logic                    dp_we_i,
  output logic                    dp_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] dp_alu_op_i,
  input  logic [DATA_LEN-1:0]     dp_src1_i,
  input  logic [DATA_LEN-1:0]     dp_src2_i,
  input  logic                    dp_src1_rdy_i,
  input  logic                    dp_src2_rdy_i,
  input  logic [RRF_TAG_LEN-1:0]  dp_dst_tag_i,
  input  logic                    dp_write_rrf_i,
  input  logic                    wb_valid_i,
  input  logic [RRF_TAG_LEN-1:0]  wb_tag_i,
  input  logic [DATA_LEN-1:0]     wb_data_i,
  output logic                    issue_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [DATA_LEN-1:0]     src1_o,
  output logic [DATA_LEN-1:0]     src2_o,
  output logic                    if_write_rrf_o,
  output logic [RRF_TAG_LEN-1:0]  dst_tag_o
);

  localparam int unsigned IdxW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  logic [ENTRY_NUM-1:0]                   valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [ENTRY_NUM-1:0]                   wrrf_q, wrrf_d;
  logic [ENTRY_NUM-1:0][ALU_OP_WIDTH-1:0] op_q, op_d;
  logic [ENTRY_NUM-1:0][DATA_LEN-1:0]     src1_q, src1_d, src2_q, src2_d;
  logic [ENTRY_NUM-1:0][RRF_TAG_LEN-1:0]  dst_q, dst_d;

  logic                    issue_q, issue_d;
  logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [DATA_LEN-1:0]     out1_q, out1_d, out2_q, out2_d;
  logic                    out_wrrf_q, out_wrrf_d;
  logic [RRF_TAG_LEN-1:0]  out_dst_q, out_dst_d;

  logic [IdxW-1:0] alloc_idx, sel_idx;
  logic            sel_found;
  logic            dp_hit1, dp_hit2;

  assign dp_ready_o = ~&valid_q;

  // Downward scan so the last assignment is the lowest index.
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IdxW'(i);
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  assign dp_hit1 = wb_valid_i && !dp_src1_rdy_i && (dp_src1_i[RRF_TAG_LEN-1:0] == wb_tag_i);
  assign dp_hit2 = wb_valid_i && !dp_src2_rdy_i && (dp_src2_i[RRF_TAG_LEN-1:0] == wb_tag_i);

  always_comb begin
    valid_d    = valid_q;
    rdy1_d     = rdy1_q;
    rdy2_d     = rdy2_q;
    wrrf_d     = wrrf_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    dst_d      = dst_q;
    issue_d    = 1'b0;
    alu_op_d   = alu_op_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    out_wrrf_d = out_wrrf_q;
    out_dst_d  = out_dst_q;

    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (wb_valid_i && valid_q[i] && !rdy1_q[i] && (src1_q[i][RRF_TAG_LEN-1:0] == wb_tag_i)) begin
        src1_d[i] = wb_data_i;
        rdy1_d[i] = 1'b1;
      end
      if (wb_valid_i && valid_q[i] && !rdy2_q[i] && (src2_q[i][RRF_TAG_LEN-1:0] == wb_tag_i)) begin
        src2_d[i] = wb_data_i;
        rdy2_d[i] = 1'b1;
      end
    end

    // The allocated entry is invalid, so it can never be the issue winner.
    if (dp_we_i && dp_ready_o) begin
      valid_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]    = dp_alu_op_i;
      src1_d[alloc_idx]  = dp_hit1 ? wb_data_i : dp_src1_i;
      src2_d[alloc_idx]  = dp_hit2 ? wb_data_i : dp_src2_i;
      rdy1_d[alloc_idx]  = dp_src1_rdy_i | dp_hit1;
      rdy2_d[alloc_idx]  = dp_src2_rdy_i | dp_hit2;
      dst_d[alloc_idx]   = dp_dst_tag_i;
      wrrf_d[alloc_idx]  = dp_write_rrf_i;
    end

    if (sel_found) begin
      valid_d[sel_idx] = 1'b0;
      issue_d          = 1'b1;
      alu_op_d         = op_q[sel_idx];
      out1_d           = src1_q[sel_idx];
      out2_d           = src2_q[sel_idx];
      out_wrrf_d       = wrrf_q[sel_idx];
      out_dst_d        = dst_q[sel_idx];
    end

    if (kill_i) begin
      valid_d = '0;
      issue_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q    <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      wrrf_q     <= '0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      issue_q    <= 1'b0;
      alu_op_q   <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out_wrrf_q <= 1'b0;
      out_dst_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      wrrf_q     <= wrrf_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dst_q      <= dst_d;
      issue_q    <= issue_d;
      alu_op_q   <= alu_op_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out_wrrf_q <= out_wrrf_d;
      out_dst_q  <= out_dst_d;
    end
  end

  assign issue_o        = issue_q;
  assign alu_op_o       = alu_op_q;
  assign src1_o         = out1_q;
  assign src2_o         = out2_q;
  assign if_write_rrf_o = out_wrrf_q;
  assign dst_tag_o      = out_dst_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: reset, ready dispatch, wakeup, bypass,
// full/priority, kill and mid-run reset.
module tb_alu_reservation_station;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        kill_i;
  logic        dp_we_i;
  logic        dp_ready_o;
  logic [3:0]  dp_alu_op_i;
  logic [31:0] dp_src1_i, dp_src2_i;
  logic        dp_src1_rdy_i, dp_src2_rdy_i;
  logic [5:0]  dp_dst_tag_i;
  logic        dp_write_rrf_i;
  logic        wb_valid_i;
  logic [5:0]  wb_tag_i;
  logic [31:0] wb_data_i;
  logic        issue_o;
  logic [3:0]  alu_op_o;
  logic [31:0] src1_o, src2_o;
  logic        if_write_rrf_o;
  logic [5:0]  dst_tag_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_reservation_station #(
    .ENTRY_NUM   (8),
    .DATA_LEN    (32),
    .RRF_TAG_LEN (6),
    .ALU_OP_WIDTH(4)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .kill_i        (kill_i),
    .dp_we_i       (dp_we_i),
    .dp_ready_o    (dp_ready_o),
    .dp_alu_op_i   (dp_alu_op_i),
    .dp_src1_i     (dp_src1_i),
    .dp_src2_i     (dp_src2_i),
    .dp_src1_rdy_i (dp_src1_rdy_i),
    .dp_src2_rdy_i (dp_src2_rdy_i),
    .dp_dst_tag_i  (dp_dst_tag_i),
    .dp_write_rrf_i(dp_write_rrf_i),
    .wb_valid_i    (wb_valid_i),
    .wb_tag_i      (wb_tag_i),
    .wb_data_i     (wb_data_i),
    .issue_o       (issue_o),
    .alu_op_o      (alu_op_o),
    .src1_o        (src1_o),
    .src2_o        (src2_o),
    .if_write_rrf_o(if_write_rrf_o),
    .dst_tag_o     (dst_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    dp_we_i    = 1'b0;
    wb_valid_i = 1'b0;
    kill_i     = 1'b0;
  endtask

  task automatic drive_dp(input logic [3:0] op, input logic [31:0] s1, input logic r1,
                          input logic [31:0] s2, input logic r2, input logic [5:0] tag,
                          input logic wr);
    dp_we_i        = 1'b1;
    dp_alu_op_i    = op;
    dp_src1_i      = s1;
    dp_src1_rdy_i  = r1;
    dp_src2_i      = s2;
    dp_src2_rdy_i  = r2;
    dp_dst_tag_i   = tag;
    dp_write_rrf_i = wr;
  endtask

  task automatic drive_wb(input logic [5:0] tag, input logic [31:0] data);
    wb_valid_i = 1'b1;
    wb_tag_i   = tag;
    wb_data_i  = data;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL reset_issue: got %b want 0", issue_o); end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", dp_ready_o); end
    n_cmp++; if ({alu_op_o, src1_o, src2_o, dst_tag_o, if_write_rrf_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs: op=%h s1=%h s2=%h tag=%h wr=%b want all 0",
                        alu_op_o, src1_o, src2_o, dst_tag_o, if_write_rrf_o);
    end
    #10 reset_i = 1'b1;
    tick();
  endtask

  task automatic test_ready_dispatch();
    drive_dp(4'h1, 32'd5, 1'b1, 32'd7, 1'b1, 6'd3, 1'b1);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL rdy_latency: issue_o=%b want 0", issue_o); end
    tick();
    n_cmp++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL rdy_issue: issue_o=%b want 1", issue_o); end
    n_cmp++; if (src1_o !== 32'd5 || src2_o !== 32'd7) begin
      n_err++; $display("FAIL rdy_srcs: src1=%0d src2=%0d want 5 7", src1_o, src2_o);
    end
    n_cmp++; if (dst_tag_o !== 6'd3 || if_write_rrf_o !== 1'b1 || alu_op_o !== 4'h1) begin
      n_err++; $display("FAIL rdy_meta: tag=%0d wr=%b op=%h want 3 1 1", dst_tag_o, if_write_rrf_o, alu_op_o);
    end
    tick();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL rdy_one_shot: issue_o=%b want 0", issue_o); end
  endtask

  task automatic test_wakeup();
    drive_dp(4'h2, 32'd1, 1'b1, 32'd9, 1'b0, 6'd10, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) drive_wb(6'd8, 32'hDEAD);
      tick();
      idle();
      n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL wake_early c=%0d: issue_o=%b want 0", c, issue_o); end
    end
    drive_wb(6'd9, 32'h1234);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL wake_latency: issue_o=%b want 0", issue_o); end
    tick();
    n_cmp++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL wake_issue: issue_o=%b want 1", issue_o); end
    n_cmp++; if (src2_o !== 32'h1234 || src1_o !== 32'd1 || dst_tag_o !== 6'd10) begin
      n_err++; $display("FAIL wake_data: src1=%h src2=%h tag=%0d want 1 1234 10", src1_o, src2_o, dst_tag_o);
    end
    tick();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL wake_one_shot: issue_o=%b want 0", issue_o); end
  endtask

  task automatic test_bypass();
    drive_dp(4'h3, 32'd4, 1'b0, 32'd2, 1'b1, 6'd11, 1'b1);
    drive_wb(6'd4, 32'hAA);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL byp_latency: issue_o=%b want 0", issue_o); end
    tick();
    n_cmp++; if (issue_o !== 1'b1 || src1_o !== 32'hAA || src2_o !== 32'd2) begin
      n_err++; $display("FAIL byp_issue: issue=%b src1=%h src2=%h want 1 aa 2", issue_o, src1_o, src2_o);
    end
    tick();
  endtask

  task automatic test_full_priority();
    // Entries 2 and 5 share source tag 30 so one broadcast wakes both.
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (dp_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready i=%0d: got %b want 1", i, dp_ready_o); end
      drive_dp(4'(i), (i == 2 || i == 5) ? 32'd30 : 32'(20 + i), 1'b0, 32'(i), 1'b1, 6'(i), 1'b0);
      tick();
    end
    idle();
    n_cmp++; if (dp_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", dp_ready_o); end
    drive_dp(4'hF, 32'd9, 1'b1, 32'd9, 1'b1, 6'd63, 1'b1);
    tick();
    idle();
    n_cmp++; if (dp_ready_o !== 1'b0 || issue_o !== 1'b0) begin
      n_err++; $display("FAIL full_drop: ready=%b issue=%b want 0 0", dp_ready_o, issue_o);
    end
    drive_wb(6'd30, 32'h55);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL prio_latency: issue_o=%b want 0", issue_o); end
    tick();
    n_cmp++; if (issue_o !== 1'b1 || dst_tag_o !== 6'd2 || src1_o !== 32'h55 || src2_o !== 32'd2) begin
      n_err++; $display("FAIL prio_first: issue=%b tag=%0d src1=%h src2=%0d want 1 2 55 2",
                        issue_o, dst_tag_o, src1_o, src2_o);
    end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_err++; $display("FAIL prio_ready: got %b want 1", dp_ready_o); end
    tick();
    n_cmp++; if (issue_o !== 1'b1 || dst_tag_o !== 6'd5 || src2_o !== 32'd5) begin
      n_err++; $display("FAIL prio_second: issue=%b tag=%0d src2=%0d want 1 5 5", issue_o, dst_tag_o, src2_o);
    end
    tick();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL prio_done: issue_o=%b want 0", issue_o); end
    kill_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_kill();
    drive_dp(4'h4, 32'd40, 1'b0, 32'd1, 1'b1, 6'd20, 1'b0);
    tick();
    drive_dp(4'h4, 32'd41, 1'b0, 32'd1, 1'b1, 6'd21, 1'b0);
    tick();
    drive_dp(4'h4, 32'd42, 1'b0, 32'd1, 1'b1, 6'd22, 1'b0);
    tick();
    drive_dp(4'h4, 32'd42, 1'b0, 32'd1, 1'b1, 6'd23, 1'b0);
    drive_wb(6'd42, 32'h77);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL kill_pre: issue_o=%b want 0", issue_o); end
    kill_i = 1'b1;
    drive_dp(4'h5, 32'd9, 1'b1, 32'd9, 1'b1, 6'd50, 1'b1);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b0 || dp_ready_o !== 1'b1) begin
      n_err++; $display("FAIL kill_now: issue=%b ready=%b want 0 1", issue_o, dp_ready_o);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL kill_after c=%0d: issue_o=%b want 0", c, issue_o); end
    end
  endtask

  task automatic test_reset_mid();
    drive_dp(4'h6, 32'd60, 1'b0, 32'd0, 1'b1, 6'd30, 1'b0);
    tick();
    drive_dp(4'h6, 32'd61, 1'b0, 32'd0, 1'b1, 6'd31, 1'b0);
    tick();
    drive_dp(4'h7, 32'd3, 1'b1, 32'd4, 1'b1, 6'd32, 1'b1);
    tick();
    drive_dp(4'h8, 32'd6, 1'b1, 32'd8, 1'b1, 6'd33, 1'b1);
    tick();
    idle();
    n_cmp++; if (issue_o !== 1'b1 || dst_tag_o !== 6'd32) begin
      n_err++; $display("FAIL rstmid_pre: issue=%b tag=%0d want 1 32", issue_o, dst_tag_o);
    end
    #2 reset_i = 1'b0;
    #1;
    n_cmp++; if (issue_o !== 1'b0 || dp_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_now: issue=%b ready=%b want 0 1", issue_o, dp_ready_o);
    end
    n_cmp++; if (src1_o !== 32'd0 || dst_tag_o !== 6'd0 || if_write_rrf_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_data: src1=%0d tag=%0d wr=%b want 0 0 0", src1_o, dst_tag_o, if_write_rrf_o);
    end
    #10 reset_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL rstmid_after c=%0d: issue_o=%b want 0", c, issue_o); end
    end
    drive_dp(4'h9, 32'd11, 1'b1, 32'd12, 1'b1, 6'd40, 1'b0);
    tick();
    idle();
    tick();
    n_cmp++; if (issue_o !== 1'b1 || src1_o !== 32'd11 || dst_tag_o !== 6'd40) begin
      n_err++; $display("FAIL rstmid_new: issue=%b src1=%0d tag=%0d want 1 11 40", issue_o, src1_o, dst_tag_o);
    end
  endtask

  initial begin
    reset_i        = 1'b0;
    idle();
    dp_alu_op_i    = '0;
    dp_src1_i      = '0;
    dp_src2_i      = '0;
    dp_src1_rdy_i  = 1'b0;
    dp_src2_rdy_i  = 1'b0;
    dp_dst_tag_i   = '0;
    dp_write_rrf_i = 1'b0;
    wb_tag_i       = '0;
    wb_data_i      = '0;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_full_priority();
    test_kill();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
